movi: RTL and testbench

- Execution FSM for the MOVI (move-immediate) instruction of the microcontroller datapath.
- On start, it places a 6-bit immediate onto the 16-bit shared bus through a tri-state buffer enable.
- It asserts the load strobe of the destination register selected by a 6-bit operand, then reports done to the control sequencer.
- Sits beside the fetch unit and the other opcode FSMs, driving register-file and port-0 input enables.

---
 rtl/movi.sv | 108 ++++++++++
 tb/tb_movi.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/movi.sv
// MOVI execution FSM: latches a destination selector and a 6-bit immediate,
// drives the immediate onto the shared bus for one cycle with the decoded
// register load strobe, then reports done until released.
// Optional: define MOVI_SIGN_EXT_EN to sign-extend the immediate instead of
// zero-extending it.
//
// Handshake: start is a level held by the control unit. The request is taken
// on the edge where start=1 in IDLE. done stays high until start drops or
// donefetch is seen.
module movi #(
  parameter int DATA_W = 16,
  parameter int ARG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              donefetch,
  input  logic              start,
  output logic              done,
  output logic              Regiin,
  input  logic [ARG_W-1:0]  parameter1,
  input  logic [ARG_W-1:0]  parameter2,
  output logic              r0in,
  output logic              r1in,
  output logic              r2in,
  output logic              r3in,
  output logic              P0in,
  output logic              buffen,
  output logic [DATA_W-1:0] bufftobus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ARG_W-1:0] dst_q, dst_d;
  logic [ARG_W-1:0] imm_q, imm_d;
  logic [DATA_W-1:0] imm_ext;

  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dst_d   = parameter1;
          imm_d   = parameter2;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = DONE;
      DONE:    if (!start || donefetch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dst_q   <= '0;
      imm_q   <= '0;
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      imm_q   <= imm_d;
    end
  end

`ifdef MOVI_SIGN_EXT_EN
  assign imm_ext = {{(DATA_W-ARG_W){imm_q[ARG_W-1]}}, imm_q};
`else
  assign imm_ext = {{(DATA_W-ARG_W){1'b0}}, imm_q};
`endif

  // Outputs are pure decodes of the registered state and operands.
  always_comb begin
    done      = 1'b0;
    Regiin    = 1'b0;
    r0in      = 1'b0;
    r1in      = 1'b0;
    r2in      = 1'b0;
    r3in      = 1'b0;
    P0in      = 1'b0;
    buffen    = 1'b0;
    bufftobus = '0;
    case (state_q)
      LOAD: begin
        buffen    = 1'b1;
        bufftobus = imm_ext;
        Regiin    = (dst_q <= ARG_W'(4));
        r0in      = (dst_q == ARG_W'(0));
        r1in      = (dst_q == ARG_W'(1));
        r2in      = (dst_q == ARG_W'(2));
        r3in      = (dst_q == ARG_W'(3));
        P0in      = (dst_q == ARG_W'(4));
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_movi.sv
// Bench for movi: directed scenarios followed by random traffic, all compared
// cycle by cycle against a transaction-level reference model.
module tb_movi;

  logic        clk = 1'b0;
  logic        rst, donefetch, start;
  logic        done, Regiin, r0in, r1in, r2in, r3in, P0in, buffen;
  logic [5:0]  parameter1, parameter2;
  logic [15:0] bufftobus;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: an instruction is either being loaded onto the bus
  // this cycle, or is complete and waiting for release.
  logic       m_loading = 1'b0;
  logic       m_waiting = 1'b0;
  int         m_dst = 0;
  int         m_imm = 0;

  always #5 clk = ~clk;

  movi dut (
    .clk(clk), .rst(rst), .donefetch(donefetch), .start(start),
    .done(done), .Regiin(Regiin),
    .parameter1(parameter1), .parameter2(parameter2),
    .r0in(r0in), .r1in(r1in), .r2in(r2in), .r3in(r3in), .P0in(P0in),
    .buffen(buffen), .bufftobus(bufftobus), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ext_imm(input int imm);
`ifdef MOVI_SIGN_EXT_EN
    return (imm >= 32) ? 16'(imm - 64) : 16'(imm);
`else
    return 16'(imm);
`endif
  endfunction

  task automatic model_step(input logic r, input logic s, input logic df,
                            input int p1, input int p2);
    if (!r) begin
      m_loading = 1'b0;
      m_waiting = 1'b0;
      m_dst = 0;
      m_imm = 0;
    end else if (m_loading) begin
      m_loading = 1'b0;
      m_waiting = 1'b1;
    end else if (m_waiting) begin
      if (!s || df) m_waiting = 1'b0;
    end else if (s) begin
      m_loading = 1'b1;
      m_dst = p1;
      m_imm = p2;
    end
  endtask

  task automatic compare_outputs();
    logic [4:0]  exp_en, got_en;
    logic        exp_reg;
    logic [15:0] exp_bus;
    exp_en  = '0;
    exp_reg = 1'b0;
    exp_bus = '0;
    if (m_loading) begin
      if (m_dst <= 4) begin
        exp_en[m_dst] = 1'b1;
        exp_reg = 1'b1;
      end
      exp_bus = ext_imm(m_imm);
    end
    got_en = {P0in, r3in, r2in, r1in, r0in};
    check("done", 32'(done), 32'(m_waiting));
    check("buffen", 32'(buffen), 32'(m_loading));
    check("bufftobus", 32'(bufftobus), 32'(exp_bus));
    check("enables", 32'(got_en), 32'(exp_en));
    check("regiin", 32'(Regiin), 32'(exp_reg));
    check("onehot", 32'($countones(got_en) <= 1), 32'd1);
  endtask

  // Drive one cycle of inputs, advance an edge, compare at the falling edge.
  task automatic cycle(input logic r, input logic s, input logic df,
                       input int p1, input int p2);
    rst = r; start = s; donefetch = df;
    parameter1 = 6'(p1); parameter2 = 6'(p2);
    @(posedge clk);
    model_step(r, s, df, p1, p2);
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    logic [15:0] sweep_bus;
    rst = 1'b0; start = 1'b0; donefetch = 1'b0;
    parameter1 = '0; parameter2 = '0;

    // Reset, then idle with start low.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    check("rst_all_zero", 32'({done, Regiin, r0in, r1in, r2in, r3in, P0in, buffen, bufftobus}), 32'd0);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("idle_done", 32'(done), 32'd0);

    // Basic MOVI R0.
    cycle(1, 1, 0, 0, 3);
    check("basic_bus", 32'(bufftobus), 32'h0003);
    check("basic_r0in", 32'(r0in), 32'd1);
    check("basic_regiin", 32'(Regiin), 32'd1);
    cycle(1, 1, 0, 0, 3);
    check("basic_done", 32'(done), 32'd1);
    check("basic_buffen_off", 32'(buffen), 32'd0);

    // Hold start high: stays done, no re-execution.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 3);
      check("hold_done", 32'(done), 32'd1);
      check("hold_no_bus", 32'(buffen), 32'd0);
    end
    cycle(1, 0, 0, 0, 3);
    check("release_done", 32'(done), 32'd0);

    // Destination sweep, including an invalid selector.
`ifdef MOVI_SIGN_EXT_EN
    sweep_bus = 16'hFFFF;
`else
    sweep_bus = 16'h003F;
`endif
    for (int d = 1; d <= 5; d++) begin
      cycle(1, 1, 0, d, 6'h3F);
      check("sweep_bus", 32'(bufftobus), 32'(sweep_bus));
      check("sweep_en", 32'({P0in, r3in, r2in, r1in, r0in}), (d <= 4) ? (32'd1 << d) : 32'd0);
      check("sweep_regiin", 32'(Regiin), (d <= 4) ? 32'd1 : 32'd0);
      cycle(1, 0, 0, d, 6'h3F);
      cycle(1, 0, 0, d, 6'h3F);
    end

    // Operands are captured only at acceptance.
    cycle(1, 1, 0, 2, 6'h15);
    check("capture_bus", 32'(bufftobus), 32'h0015);
    cycle(1, 1, 0, 2, 6'h2A);
    cycle(1, 1, 1, 2, 6'h2A);
    check("donefetch_release", 32'(done), 32'd0);
    cycle(1, 0, 0, 0, 0);

    // Reset during LOAD abandons the instruction.
    cycle(1, 1, 0, 1, 6'h09);
    check("rstload_in_load", 32'(buffen), 32'd1);
    cycle(0, 1, 0, 1, 6'h09);
    check("rstload_zero", 32'({done, Regiin, r1in, buffen, bufftobus}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0);
      check("rstload_no_done", 32'(done), 32'd0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 63)) : int'($urandom_range(0, 4)),
            int'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
